// File: rtl/asrv32_hazard_ctrl.sv
// asrv32_hazard_ctrl
//   Central pipeline sequencer for the ASRV32 IF/ID/EX pipeline.
//   Produces per-stage stall/flush controls, inserts a bubble on load-use
//   hazards, redirects fetch on taken branches/jumps, and sequences trap
//   entry and MRET through a RUN -> DRAIN -> REDIRECT state machine.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rs1_addr_id/rs2     source registers of the instruction in ID
//   i_rd_addr_ex          destination register of the instruction in EX
//   i_load_ex, i_valid_ex EX instruction is a load / is valid
//   i_exception_ex        {MRET,EBREAK,ECALL,ILLEGAL} flags of EX instruction
//   i_pc_ex               PC of EX instruction
//   i_branch_taken_ex     branch/jal/jalr in EX resolved taken
//   i_branch_target_ex    resolved branch target
//   i_mtvec, i_mepc       trap vector base / MRET return address
//   i_mem_busy            data memory wait, freezes the whole pipeline
//   o_stall_if/id         hold IF / ID
//   o_flush_if/id/ex      kill IF / ID / EX output
//   o_redirect_valid/pc   load o_redirect_pc into the fetch PC this cycle
//   o_trap_take           one-cycle pulse: write mepc/mcause
//   o_trap_mepc           PC of trapping instruction
//   o_trap_cause          mcause code (ILLEGAL=2, EBREAK=3, ECALL=11)
//   o_mret_take           one-cycle pulse: MRET retired
//
// DRAIN_CYCLES sets how many non-busy cycles the EX/MEM/WB tail gets to
// retire before the trap redirect; legal range is 1..7.

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module asrv32_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [4:0]                  i_rs1_addr_id,
  input  logic [4:0]                  i_rs2_addr_id,
  input  logic [4:0]                  i_rd_addr_ex,
  input  logic                        i_load_ex,
  input  logic                        i_valid_ex,
  input  logic [`EXCEPTION_WIDTH-1:0] i_exception_ex,
  input  logic [31:0]                 i_pc_ex,
  input  logic                        i_branch_taken_ex,
  input  logic [31:0]                 i_branch_target_ex,
  input  logic [31:0]                 i_mtvec,
  input  logic [31:0]                 i_mepc,
  input  logic                        i_mem_busy,
  output logic                        o_stall_if,
  output logic                        o_stall_id,
  output logic                        o_flush_if,
  output logic                        o_flush_id,
  output logic                        o_flush_ex,
  output logic                        o_redirect_valid,
  output logic [31:0]                 o_redirect_pc,
  output logic                        o_trap_take,
  output logic [31:0]                 o_trap_mepc,
  output logic [3:0]                  o_trap_cause,
  output logic                        o_mret_take
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_REDIRECT
  } state_t;

  state_t      state;
  logic [2:0]  drain_cnt;
  logic        is_mret_q;
  logic [31:0] trap_target_q;

  logic        exc_valid;
  logic        load_use;
  logic        branch_taken;
  logic [3:0]  cause_nxt;
  logic        mret_nxt;

  assign exc_valid    = i_valid_ex & (|i_exception_ex);
  assign branch_taken = i_valid_ex & i_branch_taken_ex;
  assign load_use     = i_valid_ex & i_load_ex & (i_rd_addr_ex != 5'd0) &
                        ((i_rd_addr_ex == i_rs1_addr_id) |
                         (i_rd_addr_ex == i_rs2_addr_id));

  // Only the highest-priority flag is acted on: ILLEGAL > ECALL > EBREAK > MRET.
  always_comb begin
    cause_nxt = '0;
    mret_nxt  = 1'b0;
    if (i_exception_ex[0])      cause_nxt = CAUSE_ILLEGAL;
    else if (i_exception_ex[1]) cause_nxt = CAUSE_ECALL;
    else if (i_exception_ex[2]) cause_nxt = CAUSE_EBREAK;
    else if (i_exception_ex[3]) mret_nxt  = 1'b1;
  end

  // FSM and trap capture; everything freezes while memory is busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_RUN;
      drain_cnt     <= '0;
      is_mret_q     <= 1'b0;
      trap_target_q <= '0;
      o_trap_mepc   <= '0;
      o_trap_cause  <= '0;
    end else if (!i_mem_busy) begin
      case (state)
        ST_RUN: begin
          if (exc_valid) begin
            state       <= ST_DRAIN;
            drain_cnt   <= DRAIN_LOAD;
            o_trap_mepc <= i_pc_ex;
            is_mret_q   <= mret_nxt;
            if (!mret_nxt) o_trap_cause <= cause_nxt;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state         <= ST_REDIRECT;
            trap_target_q <= is_mret_q ? i_mepc : (i_mtvec & 32'hFFFF_FFFC);
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        ST_REDIRECT: state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

  // Output decode. Gating with i_rst makes the asynchronous reset clear the
  // combinational RUN-state paths immediately as well as the registers.
  always_comb begin
    o_stall_if       = 1'b0;
    o_stall_id       = 1'b0;
    o_flush_if       = 1'b0;
    o_flush_id       = 1'b0;
    o_flush_ex       = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_trap_take      = 1'b0;
    o_mret_take      = 1'b0;
    if (!i_rst) begin
      if (i_mem_busy) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
      end else begin
        case (state)
          ST_RUN: begin
            // A trapping instruction suppresses branch/load-use handling;
            // the drain itself starts on the next cycle.
            if (!exc_valid) begin
              if (branch_taken) begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_branch_target_ex;
                o_flush_if       = 1'b1;
                o_flush_id       = 1'b1;
              end else if (load_use) begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_id = 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
          end
          ST_REDIRECT: begin
            o_stall_if       = 1'b1;
            o_stall_id       = 1'b1;
            o_flush_if       = 1'b1;
            o_flush_id       = 1'b1;
            o_flush_ex       = 1'b1;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = trap_target_q;
            o_trap_take      = ~is_mret_q;
            o_mret_take      = is_mret_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_asrv32_hazard_ctrl.sv
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_asrv32_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        load, valid;
  logic [3:0]  exc;
  logic [31:0] pc_ex;
  logic        br;
  logic [31:0] tgt, mtvec, mepc;
  logic        busy;

  logic        stall_if, stall_id, flush_if, flush_id, flush_ex;
  logic        rv, trap_take, mret_take;
  logic [31:0] rpc, trap_mepc;
  logic [3:0]  trap_cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  asrv32_hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_rs1_addr_id      (rs1),
    .i_rs2_addr_id      (rs2),
    .i_rd_addr_ex       (rd),
    .i_load_ex          (load),
    .i_valid_ex         (valid),
    .i_exception_ex     (exc),
    .i_pc_ex            (pc_ex),
    .i_branch_taken_ex  (br),
    .i_branch_target_ex (tgt),
    .i_mtvec            (mtvec),
    .i_mepc             (mepc),
    .i_mem_busy         (busy),
    .o_stall_if         (stall_if),
    .o_stall_id         (stall_id),
    .o_flush_if         (flush_if),
    .o_flush_id         (flush_id),
    .o_flush_ex         (flush_ex),
    .o_redirect_valid   (rv),
    .o_redirect_pc      (rpc),
    .o_trap_take        (trap_take),
    .o_trap_mepc        (trap_mepc),
    .o_trap_cause       (trap_cause),
    .o_mret_take        (mret_take)
  );

  // Control bundle: {stall_if, stall_id, flush_if, flush_id, flush_ex, redirect_valid, trap_take, mret_take}
  function automatic logic [7:0] ctl();
    return {stall_if, stall_id, flush_if, flush_id, flush_ex, rv, trap_take, mret_take};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; rd = '0; load = 1'b0; valid = 1'b0; exc = '0;
    pc_ex = '0; br = 1'b0; tgt = '0; busy = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  rs1, rs2, rd;
    logic        load, valid;
    logic [3:0]  exc;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic [7:0]  exp_ctl;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // name, rs1, rs2, rd, load, valid, exc, br, tgt, busy, exp_ctl, exp_pc
    vecs[0]  = '{"idle",            5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};
    vecs[1]  = '{"lu_rs1",          5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,   1'b0, 8'b11010000, 32'h0};
    vecs[2]  = '{"lu_rs2",          5'd3, 5'd5, 5'd5, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,   1'b0, 8'b11010000, 32'h0};
    vecs[3]  = '{"lu_rd0",          5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};
    vecs[4]  = '{"lu_nomatch",      5'd6, 5'd7, 5'd5, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};
    vecs[5]  = '{"match_notload",   5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 4'h0, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};
    vecs[6]  = '{"lu_invalid",      5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};
    vecs[7]  = '{"branch",          5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'h0, 1'b1, 32'h100, 1'b0, 8'b00110100, 32'h100};
    vecs[8]  = '{"branch_over_lu",  5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 4'h0, 1'b1, 32'h2A4, 1'b0, 8'b00110100, 32'h2A4};
    vecs[9]  = '{"branch_invalid",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 32'h100, 1'b0, 8'b00000000, 32'h0};
    vecs[10] = '{"busy_overrides",  5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 4'h0, 1'b1, 32'h100, 1'b1, 8'b11000000, 32'h0};
    vecs[11] = '{"exc_invalid",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'h2, 1'b0, 32'h0,   1'b0, 8'b00000000, 32'h0};

    // Reset state, with branch inputs active to show reset wins.
    rst = 1'b1; mtvec = 32'h203; mepc = 32'h44;
    idle_inputs();
    valid = 1'b1; br = 1'b1; tgt = 32'h100;
    #1;
    check("reset_ctl",   32'(ctl()), 32'h0);
    check("reset_rpc",   rpc, 32'h0);
    check("reset_mepc",  trap_mepc, 32'h0);
    check("reset_cause", 32'(trap_cause), 32'h0);
    tick(); tick();
    rst = 1'b0;
    idle_inputs();

    // Combinational RUN-state vectors.
    foreach (vecs[i]) begin
      tick();
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
      load = vecs[i].load; valid = vecs[i].valid; exc = vecs[i].exc;
      br = vecs[i].br; tgt = vecs[i].tgt; busy = vecs[i].busy;
      #1;
      check({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
      check({vecs[i].name, "_pc"},  rpc, vecs[i].exp_pc);
    end

    // Load-use bubble lasts one cycle: load leaves EX, hazard clears.
    tick(); idle_inputs();
    valid = 1'b1; load = 1'b1; rd = 5'd5; rs1 = 5'd5;
    #1; check("lu_seq_stall", 32'(ctl()), 32'b11010000);
    tick(); load = 1'b0; rd = 5'd9;
    #1; check("lu_seq_clear", 32'(ctl()), 32'h0);

    // ECALL at 0x40, mtvec 0x203 -> redirect to 0x200, cause 11.
    tick(); idle_inputs();
    valid = 1'b1; exc = 4'b0010; pc_ex = 32'h40;
    #1; check("ecall_detect", 32'(ctl()), 32'h0);
    tick(); idle_inputs();
    #1; check("ecall_drain1", 32'(ctl()), 32'b11111000);
    check("ecall_mepc",  trap_mepc, 32'h40);
    check("ecall_cause", 32'(trap_cause), 32'd11);
    tick(); #1; check("ecall_drain2", 32'(ctl()), 32'b11111000);
    tick(); #1; check("ecall_redir", 32'(ctl()), 32'b11111110);
    check("ecall_rpc", rpc, 32'h200);
    tick(); #1; check("ecall_run", 32'(ctl()), 32'h0);

    // MRET at 0x80, mepc 0x44; memory busy in REDIRECT holds the pulse off.
    tick(); idle_inputs();
    valid = 1'b1; exc = 4'b1000; pc_ex = 32'h80;
    #1;
    tick(); idle_inputs();
    #1; check("mret_drain1", 32'(ctl()), 32'b11111000);
    check("mret_mepc_reg", trap_mepc, 32'h80);
    tick(); #1; check("mret_drain2", 32'(ctl()), 32'b11111000);
    tick(); busy = 1'b1;
    #1; check("mret_busy_redir", 32'(ctl()), 32'b11000000);
    tick(); busy = 1'b0;
    #1; check("mret_redir", 32'(ctl()), 32'b11111101);
    check("mret_rpc", rpc, 32'h44);
    tick(); #1; check("mret_run", 32'(ctl()), 32'h0);

    // ILLEGAL|ECALL -> cause 2; branch in same cycle is suppressed;
    // 3 busy cycles in DRAIN stretch the sequence by exactly 3.
    tick(); idle_inputs();
    valid = 1'b1; exc = 4'b0011; pc_ex = 32'h60; br = 1'b1; tgt = 32'h300;
    #1; check("ill_detect", 32'(ctl()), 32'h0);
    check("ill_detect_rv", 32'(rv), 32'h0);
    tick(); idle_inputs();
    #1; check("ill_drain1", 32'(ctl()), 32'b11111000);
    check("ill_cause", 32'(trap_cause), 32'd2);
    check("ill_mepc",  trap_mepc, 32'h60);
    for (int k = 0; k < 3; k++) begin
      tick(); busy = 1'b1;
      #1; check($sformatf("ill_busy%0d", k), 32'(ctl()), 32'b11000000);
    end
    tick(); busy = 1'b0;
    #1; check("ill_drain2", 32'(ctl()), 32'b11111000);
    tick(); #1; check("ill_redir", 32'(ctl()), 32'b11111110);
    check("ill_rpc", rpc, 32'h200);
    tick(); #1; check("ill_run", 32'(ctl()), 32'h0);

    // Reset in the middle of DRAIN: immediate zero outputs, no late pulse.
    tick(); idle_inputs();
    valid = 1'b1; exc = 4'b0100; pc_ex = 32'h90;
    #1;
    tick(); idle_inputs();
    #1; check("rst_drain1", 32'(ctl()), 32'b11111000);
    rst = 1'b1;
    #1;
    check("rst_mid_ctl",   32'(ctl()), 32'h0);
    check("rst_mid_mepc",  trap_mepc, 32'h0);
    check("rst_mid_cause", 32'(trap_cause), 32'h0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst_after%0d", k), 32'(ctl()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
